// File: rtl/cond_unit_pkg.sv
// -----------------------------------------------------------------------------
// cond_unit_pkg
// Shared definitions for the Y86-64 condition-code unit:
//   - bit positions of the flags inside the 4-bit CC word
//   - jXX / cmovXX function codes for the seven defined conditions
//   - encoding of the two-state response FSM
//   - the registered verdict record handed to fetch/writeback
// -----------------------------------------------------------------------------
package cond_unit_pkg;

    // Flag positions inside cc_in / cc_out.
    localparam int ZF = 0;
    localparam int SF = 1;
    localparam int OF = 2;
    localparam int CF = 3;

    // Y86 condition function codes; 7..15 are undefined.
    localparam logic [3:0] IFUN_ALWAYS = 4'd0;
    localparam logic [3:0] IFUN_LE     = 4'd1;
    localparam logic [3:0] IFUN_L      = 4'd2;
    localparam logic [3:0] IFUN_E      = 4'd3;
    localparam logic [3:0] IFUN_NE     = 4'd4;
    localparam logic [3:0] IFUN_GE     = 4'd5;
    localparam logic [3:0] IFUN_G      = 4'd6;

    // Response FSM encoding.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // One resolved verdict. is_jmp is kept so the counters can tell a
    // jXX handshake from a cmovXX one after the request has gone.
    typedef struct packed {
        logic cnd;
        logic mispredict;
        logic illegal;
        logic is_jmp;
    } verdict_t;

endpackage : cond_unit_pkg

// File: rtl/cond_unit_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational Y86 condition evaluator.
// Ports:
//   cc      in  4  flag word (ZF, SF, OF, CF at the package indices)
//   ifun    in  4  jXX / cmovXX function code
//   cnd     out 1  condition holds
//   illegal out 1  ifun is not one of the seven defined conditions
// -----------------------------------------------------------------------------
module cond_eval
    import cond_unit_pkg::*;
(
    input  logic [3:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd,
    output logic       illegal
);

    logic zf;
    logic lt;           // signed "less than" after a compare: SF != OF
    logic unused_cf;    // CF plays no part in any Y86 condition

    assign zf        = cc[ZF];
    assign lt        = cc[SF] ^ cc[OF];
    assign unused_cf = cc[CF];

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        cnd     = 1'b0;
        illegal = 1'b0;
        case (ifun)
            IFUN_ALWAYS: cnd = 1'b1;
            IFUN_LE:     cnd = lt | zf;
            IFUN_L:      cnd = lt;
            IFUN_E:      cnd = zf;
            IFUN_NE:     cnd = ~zf;
            IFUN_GE:     cnd = ~lt;
            IFUN_G:      cnd = ~lt & ~zf;
            default:     illegal = 1'b1;
        endcase
    end

endmodule : cond_eval

// File: rtl/cond_unit.sv
// -----------------------------------------------------------------------------
// cond_unit
// Condition-code register and branch/cmov condition resolver for the Y86-64
// execute stage. Holds the ALU flags, evaluates jXX/cmovXX conditions against
// the stored flags, and returns a registered verdict over valid/ready, with
// saturating counters of resolved and mispredicted jumps.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cc_in, cc_wen       ALU flags and their set_cond strobe
//   exc_pending         later-stage exception; suppresses the CC write
//   flush               squash held response and any request this cycle
//   req_*               request: valid/ready, ifun, jXX vs cmov, prediction
//   rsp_*               registered verdict: valid/ready, cnd, mispredict,
//                       illegal
//   cc_out              current CC register
//   br_cnt, mp_cnt      resolved / mispredicted jXX counts (saturating)
// -----------------------------------------------------------------------------
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int CNT_WID = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         cc_in,
    input  logic               cc_wen,
    input  logic               exc_pending,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_ifun,
    input  logic               req_is_jmp,
    input  logic               req_pred_taken,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_cnd,
    output logic               rsp_mispredict,
    output logic               rsp_illegal,
    output logic [3:0]         cc_out,
    output logic [CNT_WID-1:0] br_cnt,
    output logic [CNT_WID-1:0] mp_cnt
);

    localparam logic [CNT_WID-1:0] CNT_ONE = CNT_WID'(1);
    localparam logic [CNT_WID-1:0] CNT_MAX = '1;

    logic [3:0]         cc_q;
    logic [0:0]         state_q;
    verdict_t           rsp_q;
    verdict_t           new_verdict;
    logic [CNT_WID-1:0] br_cnt_q;
    logic [CNT_WID-1:0] mp_cnt_q;

    logic eval_cnd;
    logic eval_illegal;
    logic accept;
    logic rsp_fire;

    // Evaluation always sees the CC value registered before this edge, so a
    // same-cycle cc_wen only affects the following request.
    cond_eval u_cond_eval (
        .cc      (cc_q),
        .ifun    (req_ifun),
        .cnd     (eval_cnd),
        .illegal (eval_illegal)
    );

    assign rsp_valid = (state_q == ST_FULL);
    assign req_ready = (!rsp_valid || rsp_ready) && !flush;
    assign accept    = req_valid && req_ready;
    // A response taken in a flush cycle is squashed, so it never counts.
    assign rsp_fire  = rsp_valid && rsp_ready && !flush;

    always_comb begin
        new_verdict.cnd        = eval_cnd;
        new_verdict.illegal    = eval_illegal;
        new_verdict.is_jmp     = req_is_jmp;
        new_verdict.mispredict = req_is_jmp && !eval_illegal &&
                                 (eval_cnd != req_pred_taken);
    end

    // CC register. A write blocked by exc_pending is lost for good.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            cc_q <= 4'b0000;
        end else if (cc_wen && !exc_pending) begin
            cc_q <= cc_in;
        end
    end

    // Response FSM: flush wins, then a new accept (which also covers the
    // simultaneous hand-off case), then a plain drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else if (accept) begin
            state_q <= ST_FULL;
        end else if (rsp_fire) begin
            state_q <= ST_EMPTY;
        end
    end

    // Verdict register; only reloaded on accept, so it is stable while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else if (accept) begin
            rsp_q <= new_verdict;
        end
    end

    // Saturating counters on legal jXX handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else if (rsp_fire && rsp_q.is_jmp && !rsp_q.illegal) begin
            if (br_cnt_q != CNT_MAX) begin
                br_cnt_q <= br_cnt_q + CNT_ONE;
            end
            if (rsp_q.mispredict && (mp_cnt_q != CNT_MAX)) begin
                mp_cnt_q <= mp_cnt_q + CNT_ONE;
            end
        end
    end

    assign rsp_cnd        = rsp_q.cnd;
    assign rsp_mispredict = rsp_q.mispredict;
    assign rsp_illegal    = rsp_q.illegal;
    assign cc_out         = cc_q;
    assign br_cnt         = br_cnt_q;
    assign mp_cnt         = mp_cnt_q;

endmodule : cond_unit

// File: doc/cond_unit.md
# cond_unit

Condition-code register and condition evaluator for the execute stage of the pipelined Y86-64 core. It sits directly behind the ALU.
- It captures the ALU's 4-bit condition codes when the ALU is told to set them.
- It resolves jXX and cmovXX conditions against the stored flags.
- It returns a registered branch/cmov verdict to fetch and writeback over a valid/ready handshake, with performance counters on resolved branches.

## Interface
Parameters:
- CNT_WID, 32, width of the saturating branch and mispredict counters.

Ports:
- clk  in  1  the only clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cc_in  in  4  flags from the ALU, indexed by ZF, SF, OF, CF.
- cc_wen  in  1  ALU set_cond strobe for this cycle.
- exc_pending  in  1  a later pipeline stage holds an exception; blocks the CC update.
- flush  in  1  squash any held response and any accepted request.
- req_valid  in  1  a jXX or cmovXX instruction is presented.
- req_ready  out  1  the request is accepted this cycle.
- req_ifun  in  4  Y86 function code.
- req_is_jmp  in  1  1 = jXX, 0 = cmovXX.
- req_pred_taken  in  1  fetch predicted taken (jXX only).
- rsp_valid  out  1  the verdict is available.
- rsp_ready  in  1  the consumer takes the verdict.
- rsp_cnd  out  1  the condition is true.
- rsp_mispredict  out  1  jXX only: rsp_cnd differs from the prediction.
- rsp_illegal  out  1  ifun is outside 0..6.
- cc_out  out  4  current CC register contents.
- br_cnt  out  CNT_WID  resolved jXX count.
- mp_cnt  out  CNT_WID  mispredicted jXX count.

## Operation
- CC register: writes cc_in when cc_wen && !exc_pending; otherwise holds.
- Condition decode, using the CC value registered at the start of the cycle:
  - 0 always = 1
  - 1 le = (SF^OF)|ZF
  - 2 l = SF^OF
  - 3 e = ZF
  - 4 ne = !ZF
  - 5 ge = !(SF^OF)
  - 6 g = !(SF^OF)&!ZF
  - 7..15 → cnd = 0 and rsp_illegal = 1
- Mispredict: rsp_mispredict = req_is_jmp && (cnd != req_pred_taken). It is 0 for cmov and for illegal ifun.
- FSM with two states:
  - EMPTY: rsp_valid = 0. An accepted request moves the FSM to FULL.
  - FULL: the response is held stable until rsp_ready. If rsp_ready and a new request arrive together, the FSM stays in FULL and loads the new verdict. If rsp_ready arrives with no new request, the FSM goes to EMPTY.
- req_ready = !rsp_valid || rsp_ready. It is 0 while flush is asserted.
- Counters:
  - br_cnt increments on the rsp handshake (rsp_valid && rsp_ready) for a legal jXX.
  - mp_cnt increments on the same handshake when rsp_mispredict is also 1.
  - Both saturate at all-ones and do not wrap.

## Timing
- Reset values: CC = 4'b0000, FSM = EMPTY, rsp_valid = 0, rsp_cnd = 0, rsp_mispredict = 0, rsp_illegal = 0, br_cnt = 0, mp_cnt = 0. req_ready is 1 after reset.
- Latency: a request accepted at edge N produces rsp_valid from edge N+1.
- Same-cycle cc_wen and request: evaluation uses the old CC. The new CC is visible from the next cycle.
- CC write with exc_pending high: dropped permanently. It is not retried later.
- flush has priority over everything except reset:
  - the next edge forces EMPTY;
  - any request in that cycle is not accepted;
  - counters do not increment for a squashed response;
  - the CC register is unaffected.
- Asserting rst_n low mid-handshake: all state clears immediately, independent of clk.
- Outputs are registered; only req_ready is combinational, from rsp_valid, rsp_ready and flush.

## Structure
- Shared header holds:
  - flag indices ZF=0, SF=1, OF=2, CF=3;
  - ifun constants for the seven conditions;
  - the FSM state encoding.
- Sub-module cond_eval: purely combinational (cc, ifun) → (cnd, illegal). The top level owns the CC register, the FSM and the counters.

## Test plan
- Reset, then no traffic: cc_out = 0 and rsp_valid = 0. Request ifun=3 (e) → rsp_cnd = 0 one cycle later.
- cc_in with ZF=1, cc_wen=1, then request jXX ifun=1 (le), pred_taken=0 → rsp_cnd = 1, rsp_mispredict = 1, br_cnt = 1 and mp_cnt = 1 after the handshake.
- cc_in with SF=1, OF=1 under exc_pending=1, then request ifun=2 (l) → cc_out unchanged (0) and rsp_cnd = 0.
- Hold rsp_ready=0 for 3 cycles → req_ready = 0 and the response stays stable. Back-to-back requests with rsp_ready=1 → one verdict per cycle.
- flush while FULL → rsp_valid = 0 next cycle and the counters are unchanged. ifun=9 → rsp_illegal = 1, rsp_cnd = 0, br_cnt not incremented.
- Preload counters near saturation via CNT_WID=4: issue 20 mispredicted jumps → br_cnt and mp_cnt both saturate at 15.
